lfsr_apple_placer: RTL and testbench
====================================

Name: lfsr_apple_placer

Overview:
- Parametrised LFSR coordinate generator for the snake playfield. It draws random (x,y) cells and checks each one against the grid occupancy store through a one-cycle lookup port.
- Retries on collision with the snake body, up to a bounded number of attempts.
- Reports the placement, or a failure, with a req/done handshake.
- Sits between the game-control FSM (placement requester) and the grid-occupancy memory.

Parameters:
- LFSR_W, 12, LFSR width; must be ≥ 2*COORD_W.
- TAPS, 12'h829, feedback tap mask (bit i set ⇒ lfsr[i] is in the XNOR); the default selects bits 11,5,3,0.
- COORD_W, 3, bits per coordinate; grid is 2**COORD_W square.
- MAX_TRIES, 8, collision attempts before reporting failure; must be ≥ 1.

Ports:
- clk  in  1  clock
- reset  in  1  async active-high reset
- seed_load  in  1  load seed_in into LFSR this edge
- seed_in  in  LFSR_W  seed value
- req  in  1  placement request, sampled only in IDLE
- busy  out  1  high in every state except IDLE
- occ_req  out  1  occupancy lookup strobe
- occ_x  out  COORD_W  lookup column
- occ_y  out  COORD_W  lookup row
- occ_hit  in  1  cell occupied; valid the cycle after occ_req
- done  out  1  one-cycle completion pulse
- fail  out  1  qualifies done: no free cell found
- apple_x  out  COORD_W  placed column, held until next done
- apple_y  out  COORD_W  placed row, held until next done

Behaviour:
- Reset: clk is the clock; reset is asynchronous and active-high.
  - lfsr=0, state=IDLE, tries=0, cand=0.
  - Outputs all 0: busy, occ_req, occ_x, occ_y, done, fail, apple_x, apple_y.
- LFSR:
  - Fibonacci, shifts left every clock (free-running, so request timing adds entropy).
  - fb = ~^(lfsr & TAPS); next = {lfsr[LFSR_W-2:0], fb}.
  - All-zero is legal. All-ones is the XNOR lockup state.
- Seed load:
  - seed_load has priority over shifting; lfsr <= seed_in.
  - seed_in all-ones loads 0 instead.
  - Loading during busy does not abort the draw.
- Candidate:
  - cand_x = lfsr[COORD_W-1:0], cand_y = lfsr[2*COORD_W-1:COORD_W].
  - Taken from the pre-edge lfsr value on the capturing edge.
- FSM states: IDLE, DRAW, CHECK, DONE.
  - IDLE: if req, capture cand, tries<=0, go to DRAW.
  - DRAW: occ_req=1, occ_x/occ_y=cand; go to CHECK.
  - CHECK: sample occ_hit.
    - occ_hit=0: apple<=cand, fail<=0, go to DONE.
    - occ_hit=1 and tries==MAX_TRIES-1: fail<=1, apple unchanged, go to DONE.
    - Otherwise: tries++, capture a fresh cand, go to DRAW.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Latency:
  - Req sampled at edge E: DRAW in cycle E..E+1, done high in cycle E+2..E+3.
  - Each retry adds 2 cycles. Worst case, done is in cycle 2*MAX_TRIES after E.
- req held high across DONE starts a new draw on the edge where the FSM is back in IDLE. req is ignored while busy.
- occ_x/occ_y read 0 outside DRAW.
- fail stays valid until the next done.
- Reset mid-operation returns to IDLE immediately with no done pulse.
- tries is sized $clog2(MAX_TRIES)+1 so it cannot wrap.

Decomposition:
- Package snake_pkg holds the state enum (IDLE, DRAW, CHECK, DONE) and the coord_t typedef (logic [COORD_W-1:0] with default 3).
- Sub-module lfsr_core: parametrised by LFSR_W/TAPS, ports clk, reset, seed_load, seed_in, state. It is reused by the snake start-position logic.
- The placer holds the FSM, try counter, and candidate/output registers.

Test Plan:
- Reset, then 3 free clocks, seed_load=0 → lfsr sequence 0x000 → 0x001 → 0x002 → 0x005.
- seed_load with seed_in=0x123 at edge e, req at edge e+1, occ_hit=0 → occ_x=3, occ_y=4 in DRAW; done two cycles later with apple=(3,4), fail=0.
- occ_hit=1 for the first lookup, then 0 → exactly 2 occ_req pulses; done 4 cycles after req; apple equals the second candidate.
- occ_hit tied 1, MAX_TRIES=8 → 8 occ_req pulses; done in cycle 16 after req with fail=1; apple_x/apple_y keep their previous values.
- seed_in=0xFFF loaded → lfsr=0x000, then 0x001 next clock (no lockup). Separately, reset asserted during CHECK → busy=0 asynchronously, no done pulse.
- req held high continuously with occ_hit=0 → done pulses every 4 cycles; busy is low for exactly one cycle between draws.

Source files
------------

// File: rtl/lfsr_apple_placer_pkg.sv
// Shared types for the snake playfield logic: FSM encoding and the default
// grid coordinate type.
package snake_pkg;

    localparam int COORD_W_DEFAULT = 3;

    typedef logic [COORD_W_DEFAULT-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/lfsr_apple_placer_if.sv
// Placement bus: request/done handshake from game control plus the
// one-cycle occupancy lookup port toward the grid memory.
interface lfsr_apple_placer_if #(
    parameter int LFSR_W  = 12,
    parameter int COORD_W = 3
);
    logic               seed_load;
    logic [LFSR_W-1:0]  seed_in;
    logic               req;
    logic               busy;
    logic               occ_req;
    logic [COORD_W-1:0] occ_x;
    logic [COORD_W-1:0] occ_y;
    logic               occ_hit;
    logic               done;
    logic               fail;
    logic [COORD_W-1:0] apple_x;
    logic [COORD_W-1:0] apple_y;

    // Environment side: game control and occupancy memory.
    modport master (
        output seed_load, seed_in, req, occ_hit,
        input  busy, occ_req, occ_x, occ_y, done, fail, apple_x, apple_y
    );

    // Placer side.
    modport slave (
        input  seed_load, seed_in, req, occ_hit,
        output busy, occ_req, occ_x, occ_y, done, fail, apple_x, apple_y
    );
endinterface

// File: rtl/lfsr_apple_placer_lfsr_core.sv
// Free-running Fibonacci XNOR LFSR with seed load; shared with the snake
// start-position logic.
module lfsr_core #(
    parameter int                LFSR_W = 12,
    parameter logic [LFSR_W-1:0] TAPS   = 12'h829
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] state_next;
    logic              fb;

    always_comb begin
        fb = ~^(state & TAPS);
        // All-ones is the XNOR lockup value, so such a seed is mapped to zero.
        if (seed_load) begin
            state_next = (&seed_in) ? '0 : seed_in;
        end else begin
            state_next = {state[LFSR_W-2:0], fb};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= '0;
        end else begin
            state <= state_next;
        end
    end

endmodule

// File: rtl/lfsr_apple_placer.sv
// Apple placer: draws LFSR candidates, probes grid occupancy, retries on
// collision and reports the placed cell or a failure with a done pulse.
module lfsr_apple_placer
    import snake_pkg::*;
#(
    parameter int                LFSR_W    = 12,
    parameter logic [LFSR_W-1:0] TAPS      = 12'h829,
    parameter int                COORD_W   = 3,
    parameter int                MAX_TRIES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    lfsr_apple_placer_if.slave   bus
);

    localparam int                TRIES_W  = $clog2(MAX_TRIES) + 1;
    localparam logic [TRIES_W-1:0] LAST_TRY = TRIES_W'(MAX_TRIES - 1);

    logic [LFSR_W-1:0]  lfsr_state;
    state_t             state_reg;
    logic [TRIES_W-1:0] tries_reg;
    logic [COORD_W-1:0] cand_x_reg;
    logic [COORD_W-1:0] cand_y_reg;
    logic [COORD_W-1:0] apple_x_reg;
    logic [COORD_W-1:0] apple_y_reg;
    logic               fail_reg;
    logic               unused_lfsr_bits;

    lfsr_core #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS)
    ) u_lfsr (
        .clk       (clk),
        .reset     (reset),
        .seed_load (bus.seed_load),
        .seed_in   (bus.seed_in),
        .state     (lfsr_state)
    );

    // Only the low 2*COORD_W bits feed the candidate; the rest is pure state.
    assign unused_lfsr_bits = ^lfsr_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            tries_reg   <= '0;
            cand_x_reg  <= '0;
            cand_y_reg  <= '0;
            apple_x_reg <= '0;
            apple_y_reg <= '0;
            fail_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.req) begin
                        cand_x_reg <= lfsr_state[COORD_W-1:0];
                        cand_y_reg <= lfsr_state[2*COORD_W-1:COORD_W];
                        tries_reg  <= '0;
                        state_reg  <= DRAW;
                    end
                end
                DRAW: begin
                    state_reg <= CHECK;
                end
                CHECK: begin
                    if (!bus.occ_hit) begin
                        apple_x_reg <= cand_x_reg;
                        apple_y_reg <= cand_y_reg;
                        fail_reg    <= 1'b0;
                        state_reg   <= DONE;
                    end else if (tries_reg == LAST_TRY) begin
                        // Previous apple is left in place on failure.
                        fail_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        tries_reg  <= tries_reg + TRIES_W'(1);
                        cand_x_reg <= lfsr_state[COORD_W-1:0];
                        cand_y_reg <= lfsr_state[2*COORD_W-1:COORD_W];
                        state_reg  <= DRAW;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = (state_reg != IDLE);
    assign bus.occ_req = (state_reg == DRAW);
    assign bus.occ_x   = (state_reg == DRAW) ? cand_x_reg : '0;
    assign bus.occ_y   = (state_reg == DRAW) ? cand_y_reg : '0;
    assign bus.done    = (state_reg == DONE);
    assign bus.fail    = fail_reg;
    assign bus.apple_x = apple_x_reg;
    assign bus.apple_y = apple_y_reg;

endmodule

// File: tb/tb_lfsr_apple_placer.sv
// Directed bench for lfsr_apple_placer: LFSR sequence, seed handling, draw,
// retry, exhaustion, async reset and back-to-back requests.
module tb_lfsr_apple_placer;
    import snake_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int lookups = 0;
    int hit_n = 0;
    int done_cnt = 0;
    int e_cyc = 0;

    lfsr_apple_placer_if #(.LFSR_W(12), .COORD_W(3)) bus();

    lfsr_apple_placer #(
        .LFSR_W    (12),
        .TAPS      (12'h829),
        .COORD_W   (3),
        .MAX_TRIES (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Advance one cycle and sample on the falling edge; the occupancy model
    // answers "occupied" for the first hit_n lookups of the current test.
    task automatic step();
        @(negedge clk);
        cycle++;
        if (bus.occ_req) begin
            lookups++;
            bus.occ_hit = (lookups <= hit_n);
        end
        if (bus.done) done_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0d want 0", bus.busy); end
        checks++; if ({bus.occ_req, bus.occ_x, bus.occ_y} !== 7'd0) begin errors++; $display("FAIL reset_occ got %0h want 0", {bus.occ_req, bus.occ_x, bus.occ_y}); end
        checks++; if ({bus.done, bus.fail} !== 2'd0) begin errors++; $display("FAIL reset_done_fail got %0h want 0", {bus.done, bus.fail}); end
        checks++; if ({bus.apple_x, bus.apple_y} !== 6'd0) begin errors++; $display("FAIL reset_apple got %0h want 0", {bus.apple_x, bus.apple_y}); end
        checks++; if (dut.u_lfsr.state !== 12'h000) begin errors++; $display("FAIL reset_lfsr got %0h want 000", dut.u_lfsr.state); end
        reset = 1'b0;
        step();
        checks++; if (dut.u_lfsr.state !== 12'h001) begin errors++; $display("FAIL lfsr_step1 got %0h want 001", dut.u_lfsr.state); end
        step();
        checks++; if (dut.u_lfsr.state !== 12'h002) begin errors++; $display("FAIL lfsr_step2 got %0h want 002", dut.u_lfsr.state); end
        step();
        checks++; if (dut.u_lfsr.state !== 12'h005) begin errors++; $display("FAIL lfsr_step3 got %0h want 005", dut.u_lfsr.state); end
        $display("reset: lfsr sequence 000 001 002 005 checked");
    endtask

    task automatic test_single_draw();
        lookups = 0;
        hit_n = 0;
        bus.seed_load = 1'b1;
        bus.seed_in = 12'h123;
        step();
        checks++; if (dut.u_lfsr.state !== 12'h123) begin errors++; $display("FAIL seed_load got %0h want 123", dut.u_lfsr.state); end
        bus.seed_load = 1'b0;
        bus.req = 1'b1;
        e_cyc = cycle + 1;
        step();
        bus.req = 1'b0;
        checks++; if ({bus.busy, bus.occ_req} !== 2'b11) begin errors++; $display("FAIL draw_strobe got %0b want 11", {bus.busy, bus.occ_req}); end
        checks++; if ({bus.occ_x, bus.occ_y} !== {3'd3, 3'd4}) begin errors++; $display("FAIL draw_coord got (%0d,%0d) want (3,4)", bus.occ_x, bus.occ_y); end
        step();
        checks++; if ({bus.occ_req, bus.occ_x, bus.occ_y} !== 7'd0) begin errors++; $display("FAIL check_occ_idle got %0h want 0", {bus.occ_req, bus.occ_x, bus.occ_y}); end
        step();
        checks++; if (bus.done !== 1'b1 || cycle - e_cyc != 2) begin errors++; $display("FAIL single_done got done=%0d at +%0d want done=1 at +2", bus.done, cycle - e_cyc); end
        checks++; if ({bus.apple_x, bus.apple_y, bus.fail} !== {3'd3, 3'd4, 1'b0}) begin errors++; $display("FAIL single_apple got (%0d,%0d) fail=%0d want (3,4) fail=0", bus.apple_x, bus.apple_y, bus.fail); end
        step();
        checks++; if ({bus.done, bus.busy} !== 2'b00) begin errors++; $display("FAIL single_after got done/busy=%0b want 00", {bus.done, bus.busy}); end
        $display("draw: apple=(%0d,%0d) fail=%0d lookups=%0d", bus.apple_x, bus.apple_y, bus.fail, lookups);
    endtask

    task automatic test_retry();
        coord_t x2 = '0;
        coord_t y2 = '0;
        lookups = 0;
        hit_n = 1;
        bus.seed_load = 1'b1;
        bus.seed_in = 12'h123;
        step();
        bus.seed_load = 1'b0;
        bus.req = 1'b1;
        e_cyc = cycle + 1;
        for (int i = 0; i < 20 && !bus.done; i++) begin
            step();
            bus.req = 1'b0;
            if (bus.occ_req && lookups == 2) begin
                x2 = bus.occ_x;
                y2 = bus.occ_y;
            end
        end
        checks++; if (bus.done !== 1'b1 || cycle - e_cyc != 4) begin errors++; $display("FAIL retry_done got done=%0d at +%0d want done=1 at +4", bus.done, cycle - e_cyc); end
        checks++; if (lookups != 2) begin errors++; $display("FAIL retry_lookups got %0d want 2", lookups); end
        checks++; if ({x2, y2} !== {3'd6, 3'd1}) begin errors++; $display("FAIL retry_cand2 got (%0d,%0d) want (6,1)", x2, y2); end
        checks++; if ({bus.apple_x, bus.apple_y, bus.fail} !== {3'd6, 3'd1, 1'b0}) begin errors++; $display("FAIL retry_apple got (%0d,%0d) fail=%0d want (6,1) fail=0", bus.apple_x, bus.apple_y, bus.fail); end
        $display("retry: apple=(%0d,%0d) fail=%0d lookups=%0d", bus.apple_x, bus.apple_y, bus.fail, lookups);
        step();
    endtask

    task automatic test_exhaust();
        lookups = 0;
        hit_n = 1000;
        bus.req = 1'b1;
        e_cyc = cycle + 1;
        for (int i = 0; i < 40 && !bus.done; i++) begin
            step();
            bus.req = 1'b0;
        end
        checks++; if (bus.done !== 1'b1 || cycle - e_cyc != 16) begin errors++; $display("FAIL exhaust_done got done=%0d at +%0d want done=1 at +16", bus.done, cycle - e_cyc); end
        checks++; if (lookups != 8) begin errors++; $display("FAIL exhaust_lookups got %0d want 8", lookups); end
        checks++; if ({bus.apple_x, bus.apple_y, bus.fail} !== {3'd6, 3'd1, 1'b1}) begin errors++; $display("FAIL exhaust_result got (%0d,%0d) fail=%0d want (6,1) fail=1", bus.apple_x, bus.apple_y, bus.fail); end
        $display("exhaust: apple=(%0d,%0d) fail=%0d lookups=%0d", bus.apple_x, bus.apple_y, bus.fail, lookups);
        step();
        step();
        checks++; if ({bus.done, bus.fail, bus.apple_x, bus.apple_y} !== {1'b0, 1'b1, 3'd6, 3'd1}) begin errors++; $display("FAIL exhaust_hold got done=%0d fail=%0d (%0d,%0d) want done=0 fail=1 (6,1)", bus.done, bus.fail, bus.apple_x, bus.apple_y); end
    endtask

    task automatic test_seed_lockup();
        bus.seed_load = 1'b1;
        bus.seed_in = 12'hFFF;
        step();
        bus.seed_load = 1'b0;
        checks++; if (dut.u_lfsr.state !== 12'h000) begin errors++; $display("FAIL lockup_load got %0h want 000", dut.u_lfsr.state); end
        step();
        checks++; if (dut.u_lfsr.state !== 12'h001) begin errors++; $display("FAIL lockup_next got %0h want 001", dut.u_lfsr.state); end
        $display("seed: all-ones load mapped to 000, then 001");
    endtask

    task automatic test_reset_mid();
        int d0;
        hit_n = 1000;
        lookups = 0;
        bus.req = 1'b1;
        step();
        bus.req = 1'b0;
        step();
        checks++; if ({bus.busy, bus.occ_req} !== 2'b10) begin errors++; $display("FAIL mid_in_check got busy/occ_req=%0b want 10", {bus.busy, bus.occ_req}); end
        d0 = done_cnt;
        reset = 1'b1;
        #1;
        checks++; if ({bus.busy, bus.done} !== 2'b00) begin errors++; $display("FAIL mid_async got busy/done=%0b want 00", {bus.busy, bus.done}); end
        step();
        step();
        reset = 1'b0;
        step();
        step();
        checks++; if (done_cnt != d0 || bus.busy !== 1'b0) begin errors++; $display("FAIL mid_no_done got dones=%0d busy=%0d want dones=%0d busy=0", done_cnt, bus.busy, d0); end
        $display("reset mid-check: busy dropped, no done pulse");
    endtask

    task automatic test_back_to_back();
        int prev;
        int dones = 0;
        int idle = 0;
        hit_n = 0;
        lookups = 0;
        bus.req = 1'b1;
        for (int i = 0; i < 10 && !bus.done; i++) step();
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_first got done=%0d want 1", bus.done); end
        prev = cycle;
        for (int i = 0; i < 16; i++) begin
            step();
            if (!bus.busy) idle++;
            if (bus.done) begin
                dones++;
                checks++; if (cycle - prev != 4) begin errors++; $display("FAIL b2b_period got %0d want 4", cycle - prev); end
                prev = cycle;
            end
        end
        checks++; if (dones != 4) begin errors++; $display("FAIL b2b_dones got %0d want 4", dones); end
        checks++; if (idle != 4) begin errors++; $display("FAIL b2b_idle got %0d want 4", idle); end
        $display("back-to-back: dones=%0d idle_cycles=%0d", dones, idle);
        bus.req = 1'b0;
        step();
        step();
    endtask

    initial begin
        bus.seed_load = 1'b0;
        bus.seed_in = '0;
        bus.req = 1'b0;
        bus.occ_hit = 1'b0;
        test_reset();
        test_single_draw();
        test_retry();
        test_exhaust();
        test_seed_lockup();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
